idli_fetch_m: RTL and testbench

Instruction fetch front end and owner of the global 2-bit sync counter. Streams 16-bit encodings nibble-serially from an external SQI serial RAM (sequential read mode) and presents each one, with a valid flag and PC, to the execution unit on counter group boundaries. Sits between the SQI memory pins and the execute stage. Handles restart on redirect (branch) and per-group stall.

---
 rtl/idli_pkg.sv | 17 +
 rtl/idli_fetch_m.sv | 84 ++++++++
 tb/tb_idli_fetch_m.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// idli_pkg: shared types, fetch FSM states and SQI setup constants
package idli_pkg;
  typedef logic [1:0] ctr_t;
  typedef logic [15:0] data_t;
  typedef logic [3:0] slice_t;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} fe_state_t;
  localparam logic [7:0] SQI_CMD_READ_DEF = 8'h03;
  localparam int FE_CMD_LEN = 2;
  localparam int FE_ADDR_LEN = 6;
  localparam int FE_DUMMY_LEN = 2;
  function automatic logic [2:0] fe_last_idx(fe_state_t s);
    return s == CMD ? 3'(FE_CMD_LEN - 1) : s == ADDR ? 3'(FE_ADDR_LEN - 1) : 3'(FE_DUMMY_LEN - 1);
  endfunction
  function automatic fe_state_t fe_next(fe_state_t s);
    return s == CMD ? ADDR : s == ADDR ? DUMMY : DATA;
  endfunction
endpackage

// File: rtl/idli_fetch_m.sv
// idli_fetch_m: SQI instruction fetch front end and owner of the 2-bit sync counter
// Ports: i_fe_gck/i_fe_rst clock and async reset; o_fe_ctr sync counter;
// o_fe_enc/o_fe_enc_vld/o_fe_pc instruction presented per group;
// i_fe_stall/i_fe_redirect/i_fe_redirect_pc group controls sampled at ctr==3;
// o_fe_sqi_* and i_fe_sqi_sio the nibble-wide serial RAM pins.
module idli_fetch_m
  import idli_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0] SQI_CMD_READ = SQI_CMD_READ_DEF
) (
  input  logic        i_fe_gck,
  input  logic        i_fe_rst,
  output ctr_t        o_fe_ctr,
  output data_t       o_fe_enc,
  output logic        o_fe_enc_vld,
  output logic [15:0] o_fe_pc,
  input  logic        i_fe_stall,
  input  logic        i_fe_redirect,
  input  logic [15:0] i_fe_redirect_pc,
  output logic        o_fe_sqi_cs_n,
  output logic        o_fe_sqi_sck_en,
  output slice_t      o_fe_sqi_sio,
  output logic        o_fe_sqi_sio_oe,
  input  slice_t      i_fe_sqi_sio
);
  fe_state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [15:0] fetch_pc, fetch_pc_n;
  logic [11:0] shreg;
  logic grp_end, redir, word_ok, sck_en_n;
  logic [23:0] byte_addr, addr_sh;
  slice_t sio_n;
  // Outputs are computed from next-state values so the registered pins line up with the state they belong to.
  always_comb begin
    grp_end = o_fe_ctr == 2'd3;
    redir = grp_end && i_fe_redirect;
    // A DATA group that was clocked captured all four nibbles, since DATA always starts at ctr==0.
    word_ok = grp_end && state == DATA && o_fe_sqi_sck_en;
    fetch_pc_n = redir ? i_fe_redirect_pc : word_ok ? fetch_pc + 16'd1 : fetch_pc;
    // Leaving IDLE after ctr==1 puts CMD on ctr==2, so the 10 setup nibbles end on a group boundary.
    state_n = redir ? IDLE : state == IDLE ? (o_fe_ctr == 2'd1 ? CMD : IDLE) : state == DATA ? DATA :
              idx == fe_last_idx(state) ? fe_next(state) : state;
    idx_n = (state_n != state || state_n == IDLE || state_n == DATA) ? 3'd0 : idx + 3'd1;
    byte_addr = {7'b0, fetch_pc_n, 1'b0};
    addr_sh = byte_addr >> {3'd5 - idx_n, 2'b00};
    sio_n = state_n == CMD ? (idx_n == 3'd0 ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0]) :
            state_n == ADDR ? addr_sh[3:0] : '0;
    // Stall gates the memory clock for a whole DATA group; stall outside DATA is ignored.
    sck_en_n = state_n != IDLE && (state != DATA || (grp_end ? !i_fe_stall : o_fe_sqi_sck_en));
  end
  always_ff @(posedge i_fe_gck or posedge i_fe_rst)
    if (i_fe_rst) begin
      o_fe_ctr <= '0;
      state <= IDLE;
      idx <= '0;
      fetch_pc <= RESET_PC;
      shreg <= '0;
      o_fe_enc <= '0;
      o_fe_enc_vld <= 1'b0;
      o_fe_pc <= RESET_PC;
      o_fe_sqi_cs_n <= 1'b1;
      o_fe_sqi_sck_en <= 1'b0;
      o_fe_sqi_sio <= '0;
      o_fe_sqi_sio_oe <= 1'b0;
    end else begin
      o_fe_ctr <= o_fe_ctr + 2'd1;
      state <= state_n;
      idx <= idx_n;
      fetch_pc <= fetch_pc_n;
      o_fe_sqi_cs_n <= state_n == IDLE;
      o_fe_sqi_sck_en <= sck_en_n;
      o_fe_sqi_sio <= sio_n;
      o_fe_sqi_sio_oe <= state_n == CMD || state_n == ADDR;
      if (state == DATA && o_fe_sqi_sck_en) shreg <= {shreg[7:0], i_fe_sqi_sio};
      if (grp_end) begin
        o_fe_enc_vld <= word_ok && !redir;
        if (word_ok && !redir) begin
          o_fe_enc <= {shreg, i_fe_sqi_sio};
          o_fe_pc <= fetch_pc;
        end
      end
    end
endmodule

// File: tb/tb_idli_fetch_m.sv
// tb_idli_fetch_m: randomized scoreboard bench for idli_fetch_m with an SQI memory model
module tb_idli_fetch_m;
  import idli_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ctr_t ctr;
  data_t enc;
  logic vld;
  logic [15:0] pc;
  logic stall = 1'b0;
  logic redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic cs_n, sck_en, sio_oe;
  slice_t sio, sio_mem = '0;
  idli_fetch_m dut (
    .i_fe_gck(clk), .i_fe_rst(rst), .o_fe_ctr(ctr), .o_fe_enc(enc), .o_fe_enc_vld(vld), .o_fe_pc(pc),
    .i_fe_stall(stall), .i_fe_redirect(redirect), .i_fe_redirect_pc(redirect_pc),
    .o_fe_sqi_cs_n(cs_n), .o_fe_sqi_sck_en(sck_en), .o_fe_sqi_sio(sio), .o_fe_sqi_sio_oe(sio_oe),
    .i_fe_sqi_sio(sio_mem)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // kind: 0 = relaunch group (cs_n high for two cycles), 1 = clocked group, 2 = stalled group
  typedef struct packed {logic vld; logic [15:0] enc; logic [15:0] pc; logic [1:0] kind;} exp_t;
  exp_t sb[$];
  logic [7:0] mem [0:131071];
  // Group-level reference: setup counts whole groups before the first capture group.
  logic [15:0] m_pc, last_enc, last_pc;
  int setup;
  logic stalled;
  task automatic model_init();
    m_pc = 16'h0000; last_enc = '0; last_pc = 16'h0000; setup = 3; stalled = 1'b0;
    sb.push_back(exp_t'{1'b0, 16'h0000, 16'h0000, 2'd0});
  endtask
  task automatic model_push(logic s, logic r, logic [15:0] rpc);
    logic cap, ns;
    cap = setup == 0 && !stalled;
    if (r) begin
      sb.push_back(exp_t'{1'b0, last_enc, last_pc, 2'd0});
      m_pc = rpc; setup = 3; stalled = 1'b0;
    end else begin
      if (cap) begin
        last_enc = {mem[{m_pc, 1'b0}], mem[{m_pc, 1'b1}]};
        last_pc = m_pc;
        m_pc = m_pc + 16'd1;
      end
      ns = setup == 0 && s;
      if (setup > 0) setup--;
      stalled = ns;
      sb.push_back(exp_t'{cap, last_enc, last_pc, ns ? 2'd2 : 2'd1});
    end
  endtask
  // SQI memory: sequential read, data launched after the edge so the DUT samples it on the next one.
  int mc = 0;
  logic [7:0] rx_cmd = '0;
  logic [23:0] rx_addr = '0;
  logic [16:0] ptr = '0;
  logic half = 1'b0;
  always @(posedge clk) begin
    if (cs_n) mc <= 0;
    else if (sck_en) begin
      if (mc < 10) mc <= mc + 1;
      if (mc < 8) chk("sio_oe_setup", 32'(sio_oe), 32'd1);
      else chk("sio_oe_rx", 32'(sio_oe), 32'd0);
      if (mc < 2) rx_cmd <= {rx_cmd[3:0], sio};
      if (mc == 1) chk("sqi_cmd", 32'({rx_cmd[3:0], sio}), 32'h03);
      if (mc >= 2 && mc < 8) rx_addr <= {rx_addr[19:0], sio};
      if (mc == 7) chk("sqi_addr", 32'({rx_addr[19:0], sio}), 32'({7'b0, m_pc, 1'b0}));
      if (mc == 9) begin
        ptr <= rx_addr[16:0];
        half <= 1'b1;
        sio_mem <= mem[rx_addr[16:0]][7:4];
      end else if (mc >= 10) begin
        if (half) begin
          sio_mem <= mem[ptr][3:0];
          half <= 1'b0;
        end else begin
          ptr <= ptr + 17'd1;
          half <= 1'b1;
          sio_mem <= mem[ptr + 17'd1][7:4];
        end
      end
    end
  end
  // Monitor: pops one expectation per group and checks every cycle of it on the falling edge.
  initial begin
    int mcnt;
    exp_t cur;
    logic [1:0] ph;
    mcnt = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mcnt = 0;
        continue;
      end
      ph = 2'(mcnt);
      chk("ctr", 32'(ctr), 32'(ph));
      if (ph == 2'd0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got no expectation required one at %0t", $time);
        end else cur = sb.pop_front();
      end
      chk("cs_n", 32'(cs_n), 32'(cur.kind == 2'd0 && ph < 2'd2));
      chk("sck_en", 32'(sck_en), 32'(cur.kind == 2'd1 || (cur.kind == 2'd0 && ph >= 2'd2)));
      chk("enc_vld", 32'(vld), 32'(cur.vld));
      chk("enc", 32'(enc), 32'(cur.enc));
      chk("pc", 32'(pc), 32'(cur.pc));
      mcnt++;
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_init();
  endtask
  // Called at ctr==0; noise on the controls at ctr 0..2 must be ignored.
  task automatic run_group(logic s, logic r, logic [15:0] rpc);
    for (int c = 0; c < 3; c++) begin
      stall = 1'($urandom);
      redirect = 1'($urandom);
      redirect_pc = 16'($urandom);
      @(posedge clk);
      #1;
    end
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    model_push(s, r, rpc);
    @(posedge clk);
    #1;
    stall = 1'b0;
    redirect = 1'b0;
  endtask
  task automatic set_base();
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
  endtask
  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    set_base();
    do_reset();
    repeat (4) run_group(1'b0, 1'b0, 16'h0);
    chk("first_enc", 32'(enc), 32'h1234);
    chk("first_pc", 32'(pc), 32'h0000);
    chk("first_vld", 32'(vld), 32'd1);
    run_group(1'b0, 1'b0, 16'h0);
    chk("second_enc", 32'(enc), 32'h5678);
    chk("second_pc", 32'(pc), 32'h0001);
    repeat (2) run_group(1'b0, 1'b0, 16'h0);
    run_group(1'b0, 1'b1, 16'h0100);
    repeat (7) run_group(1'b0, 1'b0, 16'h0);
    repeat (2) run_group(1'b1, 1'b0, 16'h0);
    repeat (3) run_group(1'b0, 1'b0, 16'h0);
    run_group(1'b0, 1'b1, 16'h0200);
    repeat (2) run_group(1'b1, 1'b0, 16'h0);
    repeat (4) run_group(1'b0, 1'b0, 16'h0);
    mem[0] = 8'hEF; mem[1] = 8'h01; mem[17'h1FFFE] = 8'hAB; mem[17'h1FFFF] = 8'hCD;
    run_group(1'b0, 1'b1, 16'hFFFF);
    repeat (4) run_group(1'b0, 1'b0, 16'h0);
    chk("wrap_enc0", 32'(enc), 32'hABCD);
    chk("wrap_pc0", 32'(pc), 32'hFFFF);
    run_group(1'b0, 1'b0, 16'h0);
    chk("wrap_enc1", 32'(enc), 32'hEF01);
    chk("wrap_pc1", 32'(pc), 32'h0000);
    repeat (2) run_group(1'b0, 1'b0, 16'h0);
    for (int g = 0; g < 150; g++)
      run_group($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, 16'($urandom));
    repeat (6) run_group(1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_cs_n", 32'(cs_n), 32'd1);
    chk("async_vld", 32'(vld), 32'd0);
    chk("async_ctr", 32'(ctr), 32'd0);
    set_base();
    do_reset();
    repeat (4) run_group(1'b0, 1'b0, 16'h0);
    chk("restart_enc", 32'(enc), 32'h1234);
    chk("restart_pc", 32'(pc), 32'h0000);
    repeat (2) run_group(1'b0, 1'b0, 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
